// File: rtl/insn_loader.sv
// Byte-stream program loader: assembles 9-bit instructions from byte pairs and
// writes them to consecutive instruction-RAM addresses, tracking a checksum.
module insn_loader #(
    parameter int unsigned IW = 16
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          start,
    input  logic [IW-1:0] base_addr,
    input  logic [IW:0]   word_count,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [IW-1:0] mem_addr,
    output logic [8:0]    mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [8:0]    checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WRITE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] addr_q, addr_d;
    logic [IW:0]   remaining_q, remaining_d;
    logic          insn_hi_q, insn_hi_d;
    logic [IW-1:0] mem_addr_q, mem_addr_d;
    logic [8:0]    mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [8:0]    checksum_q, checksum_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        insn_hi_d   = insn_hi_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        done_d      = 1'b0;
        error_d     = error_q;
        checksum_d  = checksum_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = word_count;
                    checksum_d  = '0;
                    error_d     = 1'b0;
                    if (word_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (in_valid && in_ready_q) begin
                    // Only bit 0 of the high byte carries data; anything else aborts the load.
                    if (in_data[7:1] != '0) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        insn_hi_d = in_data[0];
                        state_d   = S_LO;
                    end
                end
            end
            S_LO: begin
                if (in_valid && in_ready_q) begin
                    mem_addr_d  = addr_q;
                    mem_wdata_d = {insn_hi_q, in_data};
                    mem_we_d    = 1'b1;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                checksum_d  = checksum_q + mem_wdata_q;
                addr_d      = addr_q + IW'(1);
                remaining_d = remaining_q - (IW+1)'(1);
                if (remaining_q == (IW+1)'(1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HI;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake/status outputs are registered from the next state.
        busy_d     = (state_d != S_IDLE);
        in_ready_d = (state_d == S_HI) || (state_d == S_LO);
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            insn_hi_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            insn_hi_q   <= insn_hi_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            checksum_q  <= checksum_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_insn_loader.sv
// Scoreboard bench for insn_loader: expected RAM writes are queued as bytes are
// driven and popped when mem_we is observed; a 4-bit-address instance covers wrap.
module tb_insn_loader;

    typedef struct packed {
        logic [15:0] a;
        logic [8:0]  d;
    } wr_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        reset_n;
    logic        start;
    logic [15:0] base_addr;
    logic [16:0] word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, busy, done, error;
    logic [15:0] mem_addr;
    logic [8:0]  mem_wdata, checksum;

    logic        s4_start, s4_valid;
    logic [3:0]  s4_base;
    logic [4:0]  s4_count;
    logic [7:0]  s4_data;
    logic        s4_ready, s4_we, s4_busy, s4_done, s4_error;
    logic [3:0]  s4_addr;
    logic [8:0]  s4_wdata, s4_sum;

    insn_loader #(.IW(16)) dut16 (
        .CLK(CLK), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error),
        .checksum(checksum)
    );

    insn_loader #(.IW(4)) dut4 (
        .CLK(CLK), .reset_n(reset_n), .start(s4_start), .base_addr(s4_base),
        .word_count(s4_count), .in_valid(s4_valid), .in_data(s4_data),
        .in_ready(s4_ready), .mem_we(s4_we), .mem_addr(s4_addr),
        .mem_wdata(s4_wdata), .busy(s4_busy), .done(s4_done), .error(s4_error),
        .checksum(s4_sum)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    wr_t         exp_q[$];
    wr_t         exp4_q[$];
    wr_t         mon_w, mon4_w;
    logic [15:0] cur_addr;
    logic [8:0]  exp_sum;
    logic        stress_start = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("we_unexpected", 1, 0);
            end else begin
                mon_w = exp_q.pop_front();
                check("wr_addr", mem_addr, mon_w.a);
                check("wr_data", mem_wdata, mon_w.d);
            end
        end
    end

    always @(negedge CLK) begin
        if (s4_we === 1'b1) begin
            if (exp4_q.size() == 0) begin
                check("we4_unexpected", 1, 0);
            end else begin
                mon4_w = exp4_q.pop_front();
                check("wr4_addr", s4_addr, mon4_w.a);
                check("wr4_data", s4_wdata, mon4_w.d);
            end
        end
    end

    // Presents one byte (after optional idle gap) and returns on the negedge after transfer.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int k = 0;
        for (int i = 0; i < gap; i++) begin
            in_valid   = 1'b0;
            in_data    = 8'($urandom);
            start      = stress_start;
            base_addr  = 16'($urandom);
            word_count = 17'($urandom);
            @(negedge CLK);
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && k < 50) begin
            @(negedge CLK);
            k++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic hi, input logic [7:0] lo, input int gap);
        exp_q.push_back('{a: cur_addr, d: {hi, lo}});
        exp_sum  = exp_sum + {hi, lo};
        cur_addr = cur_addr + 16'd1;
        send_byte({7'b0, hi}, gap);
        send_byte(lo, gap);
    endtask

    task automatic begin_load(input logic [15:0] base, input logic [16:0] count);
        start      = 1'b1;
        base_addr  = base;
        word_count = count;
        cur_addr   = base;
        exp_sum    = '0;
        @(negedge CLK);
        start = 1'b0;
        check("load_busy", busy, 1);
        check("load_ready", in_ready, 1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 100) begin
            @(negedge CLK);
            k++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_sum"}, checksum, exp_sum);
        check({tag, "_busy"}, busy, 0);
        @(negedge CLK);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] tbl[5];
        logic [7:0] tbl4[5];
        reset_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        in_valid = 1'b0; in_data = '0;
        s4_start = 1'b0; s4_base = '0; s4_count = '0; s4_valid = 1'b0; s4_data = '0;
        cur_addr = '0; exp_sum = '0;
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_sum", checksum, 0);
        repeat (2) @(negedge CLK);
        reset_n = 1'b1;

        // Idle: offered bytes must not be taken.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h11 * (i + 1));
            @(negedge CLK);
            check("idle_ready", in_ready, 0);
            check("idle_busy", busy, 0);
        end

        // Cycle-exact load with in_valid held high.
        tbl = '{8'h01, 8'h23, 8'h5A, 8'h00, 8'hFF};
        exp_q.push_back('{a: 16'h0010, d: 9'h123});
        exp_q.push_back('{a: 16'h0011, d: 9'h0FF});
        in_valid = 1'b1; in_data = 8'hEE;
        start = 1'b1; base_addr = 16'h0010; word_count = 17'd2;
        @(negedge CLK);
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            check("t2_ready", in_ready, (k == 1 || k == 2 || k == 4 || k == 5));
            check("t2_we", mem_we, (k == 3 || k == 6));
            check("t2_busy", busy, (k <= 6));
            check("t2_done", done, (k == 7));
            if (k == 7) check("t2_sum", checksum, 9'h022);
            if (k <= 5) in_data = tbl[k-1];
            @(negedge CLK);
        end
        in_valid = 1'b0;
        check("t2_done_pulse", done, 0);

        // Address wrap on the 4-bit instance.
        tbl4 = '{8'h00, 8'h05, 8'h77, 8'h01, 8'h00};
        exp4_q.push_back('{a: 16'h000F, d: 9'h005});
        exp4_q.push_back('{a: 16'h0000, d: 9'h100});
        s4_valid = 1'b1; s4_start = 1'b1; s4_base = 4'hF; s4_count = 5'd2;
        @(negedge CLK);
        s4_start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            check("wrap_we", s4_we, (k == 3 || k == 6));
            check("wrap_done", s4_done, (k == 7));
            if (k == 7) check("wrap_sum", s4_sum, 9'h105);
            if (k <= 5) s4_data = tbl4[k-1];
            @(negedge CLK);
        end
        s4_valid = 1'b0;

        // Malformed high byte aborts; next start clears error.
        begin_load(16'h0100, 17'd3);
        in_valid = 1'b1; in_data = 8'h02;
        @(negedge CLK);
        in_valid = 1'b0;
        check("bad_error", error, 1);
        check("bad_busy", busy, 0);
        check("bad_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            check("bad_no_done", done, 0);
            @(negedge CLK);
        end
        check("bad_error_sticky", error, 1);
        begin_load(16'h0200, 17'd1);
        check("restart_clears_error", error, 0);
        send_word(1'b0, 8'hAA, 0);
        wait_done("single");

        // Zero-length load.
        start = 1'b1; base_addr = 16'h0055; word_count = '0;
        @(negedge CLK);
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        @(negedge CLK);
        check("zero_done_pulse", done, 0);
        check("zero_busy2", busy, 0);

        // Random gaps with spurious starts while busy.
        begin_load(16'h0300, 17'd4);
        stress_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_word(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                      int'($urandom_range(1, 3)));
        end
        stress_start = 1'b0;
        start = 1'b0;
        wait_done("stress");

        // Reset during a load: second word never written.
        begin_load(16'h0400, 17'd3);
        send_word(1'b1, 8'h11, 0);
        send_byte(8'h00, 0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_sum", checksum, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        in_valid = 1'b1; in_data = 8'h34;
        @(negedge CLK);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
        end
        in_valid = 1'b0;

        check("sb_empty", exp_q.size(), 0);
        check("sb4_empty", exp4_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/insn_loader.md
# insn_loader

Sequential program loader that fills a writable 9-bit-wide, 2**IW-deep instruction memory from a byte stream, so programs can be loaded at run time instead of only from a file at elaboration. Sits between a host/testbench byte source (valid/ready) and the write port of the instruction RAM. The instruction fetch side reads that RAM combinationally by address, unchanged. Each instruction arrives as two bytes and is written at consecutive addresses from a programmable base. The block keeps a running checksum and flags malformed input.

## Interface
- IW, 16: address width; memory depth 2**IW.
- CLK  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  in  IW  first write address; latched on accepted start.
- word_count  in  IW+1  number of instructions to load (0..2**IW); latched on accepted start.
- in_valid  in  1  byte source has data.
- in_data  in  8  byte from source.
- in_ready  out  1  loader accepts a byte this cycle; transfer when in_valid && in_ready.
- mem_we  out  1  instruction RAM write enable, one cycle per instruction.
- mem_addr  out  IW  write address.
- mem_wdata  out  9  instruction to write.
- busy  out  1  load in progress (state not IDLE).
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky; malformed high byte seen; cleared by next accepted start.
- checksum  out  9  sum mod 512 of all words written since last accepted start.

## Operation
- States: IDLE, HI, LO, WRITE.
- IDLE: in_ready=0, mem_we=0, busy=0. On start: latch base_addr into address register, word_count into remaining counter, clear checksum and error. If word_count==0 -> stay IDLE, pulse done next cycle. Else -> HI.
- HI: in_ready=1. On transfer: in_data[7:1] must be 0; if nonzero -> error=1, -> IDLE (load aborted, no write, done not pulsed). Else latch in_data[0] as insn[8], -> LO.
- LO: in_ready=1. On transfer: latch in_data as insn[7:0], -> WRITE.
- WRITE: in_ready=0, mem_we=1, mem_addr=current address, mem_wdata=assembled insn. At edge: checksum += insn (mod 512), address += 1 (mod 2**IW, all-ones wraps to 0), remaining -= 1. If remaining becomes 0 -> IDLE with done=1 for the following cycle; else -> HI.
- start while busy: ignored; no effect on latched values.
- No-valid cycles in HI/LO: hold state indefinitely, no timeout.
- word_count = 2**IW: fills the whole memory, address wraps back to base.
- mem_addr, mem_wdata: registered, hold last values outside WRITE; only meaningful when mem_we=1.

## Timing
- Reset (async, immediate): state IDLE; in_ready, mem_we, busy, done, error = 0; mem_addr, mem_wdata, checksum = 0.
- Reset asserted mid-load: partial load abandoned, already-written words remain in RAM, no done pulse.
- start accepted at edge t0: busy=1 and in_ready=1 in cycle after t0.
- Per instruction: minimum 3 cycles (HI transfer, LO transfer, WRITE). in_ready low during WRITE.
- mem_we is high in exactly the cycle after the LO transfer edge; the RAM captures on the edge ending that cycle.
- done and busy=0 appear together in the cycle after the final WRITE. checksum is final in that same cycle.
- in_ready depends only on state, never combinationally on in_valid.

## Test plan
- Reset then idle: all outputs 0; in_valid=1 with bytes -> no transfer, mem_we stays 0.
- Load base=0x0010, count=2, bytes 01 23 00 FF, in_valid always high -> writes 0x123@0x0010, 0x0FF@0x0011; mem_we high in cycles 3 and 6 after start; done pulse; checksum=0x022.
- Wrap: IW=4, base=0xF, count=2, bytes 00 05 01 00 -> writes 0x005@0xF, 0x100@0x0; checksum=0x105.
- Bad high byte 0x02 as first byte -> error=1, back to IDLE, no mem_we, no done; next start clears error.
- count=0 -> done pulse one cycle after start, no writes, busy never high; start during load and random in_valid gaps -> ignored, data/addresses unchanged.
- reset_n pulsed low after first word written -> outputs immediately 0, no second write, no done.
